// File: rtl/bram_sp_be.sv
// Single-port synchronous block RAM with byte-lane write enables,
// 1- or 2-cycle read latency, selectable read-during-write behaviour and
// a post-reset clear sweep.
//
// Ports:
//   clka   - clock, all logic on the rising edge
//   rsta   - synchronous active-high reset (highest priority)
//   ena    - port enable; an access happens when ena=1 and busy=0
//   wea    - byte-lane write enables (all zero = read)
//   addra  - word address
//   dina   - write data
//   douta  - registered read data
//   rvalid - one-cycle pulse marking each douta update caused by an access
//   busy   - high while the clear sweep runs; accesses are ignored
module bram_sp_be #(
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter int unsigned            COL_WIDTH      = 8,
    parameter int unsigned            ADDR_WIDTH     = 16,
    parameter int unsigned            READ_LATENCY   = 1,
    parameter int unsigned            WRITE_MODE     = 0,
    parameter int unsigned            CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE    = '0
) (
    input  logic                             clka,
    input  logic                             rsta,
    input  logic                             ena,
    input  logic [DATA_WIDTH/COL_WIDTH-1:0]  wea,
    input  logic [ADDR_WIDTH-1:0]            addra,
    input  logic [DATA_WIDTH-1:0]            dina,
    output logic [DATA_WIDTH-1:0]            douta,
    output logic                             rvalid,
    output logic                             busy
);

    localparam int unsigned NB_COL      = DATA_WIDTH / COL_WIDTH;
    localparam int unsigned DEPTH       = 2 ** ADDR_WIDTH;
    localparam int unsigned MODE_RFIRST = 0;
    localparam int unsigned MODE_WFIRST = 1;
    localparam int unsigned MODE_NOCHG  = 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Reject unsupported configurations at elaboration.
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("bram_sp_be: READ_LATENCY must be 1 or 2");
    end
    if (WRITE_MODE > MODE_NOCHG) begin : g_bad_mode
        $error("bram_sp_be: WRITE_MODE must be 0, 1 or 2");
    end
    if ((DATA_WIDTH % COL_WIDTH) != 0) begin : g_bad_col
        $error("bram_sp_be: DATA_WIDTH must be a multiple of COL_WIDTH");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  v1_q, v1_d;

    logic                  access_c;
    logic                  is_write_c;
    logic                  upd_c;
    logic [NB_COL-1:0]     wr_lane_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic [DATA_WIDTH-1:0] old_word_c;
    logic [DATA_WIDTH-1:0] merged_c;

    // Control FSM: clear sweep sequencing and access gating.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        access_c  = 1'b0;
        wr_lane_c = '0;
        wr_addr_c = addra;
        wr_data_c = dina;
        if (rsta) begin
            state_d = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            ptr_d   = '0;
            busy_d  = (CLEAR_ON_RESET != 0);
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    wr_lane_c = '1;
                    wr_addr_c = ptr_q;
                    wr_data_c = CLEAR_VALUE;
                    ptr_d     = ptr_q + ADDR_WIDTH'(1);
                    if (ptr_q == LAST_ADDR) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                ST_IDLE: begin
                    access_c = ena && !busy_q;
                    if (access_c) begin
                        wr_lane_c = wea;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Read-side data: old word for read-first, lane-merged word for write-first.
    always_comb begin
        old_word_c = mem[addra];
        merged_c   = old_word_c;
        for (int i = 0; i < NB_COL; i++) begin
            if (wea[i]) begin
                merged_c[i*COL_WIDTH +: COL_WIDTH] = dina[i*COL_WIDTH +: COL_WIDTH];
            end
        end
        is_write_c = |wea;
        // A no-change write produces neither a data update nor a valid pulse.
        upd_c      = access_c && !(is_write_c && WRITE_MODE == MODE_NOCHG);
        rd_data_d  = rd_data_q;
        if (upd_c) begin
            rd_data_d = (is_write_c && WRITE_MODE == MODE_WFIRST) ? merged_c : old_word_c;
        end
        v1_d = upd_c;
    end

    // Memory array write port (byte lanes); contents are never reset.
    always_ff @(posedge clka) begin
        for (int i = 0; i < NB_COL; i++) begin
            if (wr_lane_c[i]) begin
                mem[wr_addr_c][i*COL_WIDTH +: COL_WIDTH] <= wr_data_c[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end

    // Control and first read stage registers.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            ptr_q     <= '0;
            busy_q    <= (CLEAR_ON_RESET != 0);
            rd_data_q <= '0;
            v1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            v1_q      <= v1_d;
        end
    end

    assign busy = busy_q;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] douta_q, douta_d;
        logic                  rvalid_q, rvalid_d;

        // Second stage only captures when the first stage holds fresh data.
        always_comb begin
            douta_d  = douta_q;
            rvalid_d = v1_q;
            if (v1_q) begin
                douta_d = rd_data_q;
            end
        end

        always_ff @(posedge clka) begin
            if (rsta) begin
                douta_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                douta_q  <= douta_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign douta  = douta_q;
        assign rvalid = rvalid_q;
    end else begin : g_lat1
        assign douta  = rd_data_q;
        assign rvalid = v1_q;
    end

endmodule

// File: tb/tb_bram_sp_be.sv
// Directed bench for bram_sp_be: four 16-word instances share one stimulus
// stream (read-first, write-first and no-change at latency 1, read-first at
// latency 2); each check looks at the instance whose behaviour it targets.
module tb_bram_sp_be;

    logic        clk;
    logic        rsta;
    logic        ena;
    logic [3:0]  wea;
    logic [3:0]  addra;
    logic [31:0] dina;

    logic [31:0] douta_rf, douta_wf, douta_nc, douta_l2;
    logic        rvalid_rf, rvalid_wf, rvalid_nc, rvalid_l2;
    logic        busy_rf, busy_wf, busy_nc, busy_l2;

    int total = 0;
    int bad   = 0;

    bram_sp_be #(.ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) u_rf (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_rf), .rvalid(rvalid_rf), .busy(busy_rf));
    bram_sp_be #(.ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_MODE(1), .CLEAR_ON_RESET(1)) u_wf (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_wf), .rvalid(rvalid_wf), .busy(busy_wf));
    bram_sp_be #(.ADDR_WIDTH(4), .READ_LATENCY(1), .WRITE_MODE(2), .CLEAR_ON_RESET(1)) u_nc (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_nc), .rvalid(rvalid_nc), .busy(busy_nc));
    bram_sp_be #(.ADDR_WIDTH(4), .READ_LATENCY(2), .WRITE_MODE(0), .CLEAR_ON_RESET(1)) u_l2 (
        .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .douta(douta_l2), .rvalid(rvalid_l2), .busy(busy_l2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        ena = 1'b1; wea = be; addra = a; dina = d;
        tick();
        ena = 1'b0; wea = 4'h0;
    endtask

    task automatic rd(input logic [3:0] a);
        ena = 1'b1; wea = 4'h0; addra = a;
        tick();
        ena = 1'b0;
    endtask

    // Counts edges for which busy stays high, starting just after the reset edge.
    task automatic sweep_len(output int n);
        n = 0;
        for (int k = 0; k < 100 && busy_rf; k++) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rsta = 1'b1; ena = 1'b0; wea = 4'h0; addra = 4'h0; dina = 32'h0;

        // Reset state.
        tick();
        chk("reset_busy_rf",   32'(busy_rf),   32'd1);
        chk("reset_busy_l2",   32'(busy_l2),   32'd1);
        chk("reset_douta_rf",  douta_rf,       32'h0);
        chk("reset_rvalid_rf", 32'(rvalid_rf), 32'd0);
        chk("reset_douta_l2",  douta_l2,       32'h0);
        rsta = 1'b0;
        sweep_len(n);
        chk("initial_sweep_len", 32'(n), 32'd16);

        // Clear sweep wipes a fully written array.
        for (int a = 0; a < 16; a++) wr(4'(a), 32'hFFFF_FFFF, 4'hF);
        rsta = 1'b1;
        tick();
        rsta = 1'b0;
        sweep_len(n);
        chk("clear_sweep_len", 32'(n), 32'd16);
        chk("clear_busy_l2",   32'(busy_l2), 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            chk($sformatf("clear_rd_data[%0d]", a), douta_rf, 32'h0);
            chk($sformatf("clear_rd_vld[%0d]", a), 32'(rvalid_rf), 32'd1);
        end

        // Byte lanes.
        wr(4'd2, 32'h1110_1010, 4'hF);
        wr(4'd2, 32'hAABB_CCDD, 4'h5);
        rd(4'd2);
        chk("lanes_douta",  douta_rf, 32'h11BB_10DD);
        chk("lanes_rvalid", 32'(rvalid_rf), 32'd1);

        // Write modes.
        wr(4'd2, 32'h1110_1010, 4'hF);
        wr(4'd5, 32'h0000_0055, 4'hF);
        rd(4'd5);
        chk("prior_nc", douta_nc, 32'h0000_0055);
        wr(4'd2, 32'hDEAD_BEEF, 4'hF);
        chk("rfirst_douta",  douta_rf, 32'h1110_1010);
        chk("rfirst_rvalid", 32'(rvalid_rf), 32'd1);
        chk("wfirst_douta",  douta_wf, 32'hDEAD_BEEF);
        chk("wfirst_rvalid", 32'(rvalid_wf), 32'd1);
        chk("nochg_douta",   douta_nc, 32'h0000_0055);
        chk("nochg_rvalid",  32'(rvalid_nc), 32'd0);
        rd(4'd2);
        chk("nochg_written", douta_nc, 32'hDEAD_BEEF);

        // Latency 2, back-to-back reads.
        wr(4'd0, 32'h0000_00A0, 4'hF);
        wr(4'd1, 32'h0000_00A1, 4'hF);
        wr(4'd2, 32'h0000_00A2, 4'hF);
        tick(); tick(); tick();
        ena = 1'b1; wea = 4'h0; addra = 4'd0;
        tick();
        chk("l2_e0_rvalid", 32'(rvalid_l2), 32'd0);
        chk("l1_e0_douta",  douta_rf, 32'h0000_00A0);
        addra = 4'd1;
        tick();
        chk("l2_e1_douta",  douta_l2, 32'h0000_00A0);
        chk("l2_e1_rvalid", 32'(rvalid_l2), 32'd1);
        addra = 4'd2;
        tick();
        ena = 1'b0;
        chk("l2_e2_douta",  douta_l2, 32'h0000_00A1);
        chk("l2_e2_rvalid", 32'(rvalid_l2), 32'd1);
        tick();
        chk("l2_e3_douta",  douta_l2, 32'h0000_00A2);
        chk("l2_e3_rvalid", 32'(rvalid_l2), 32'd1);
        tick();
        chk("l2_e4_douta",  douta_l2, 32'h0000_00A2);
        chk("l2_e4_rvalid", 32'(rvalid_l2), 32'd0);

        // Hold with ena low, even with write-looking inputs present.
        wr(4'd2, 32'h1110_1010, 4'hF);
        rd(4'd2);
        chk("hold_start", douta_rf, 32'h1110_1010);
        wea = 4'hF; addra = 4'd2; dina = 32'h0BAD_0BAD;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hold_douta[%0d]", c), douta_rf, 32'h1110_1010);
            chk($sformatf("hold_rvalid[%0d]", c), 32'(rvalid_rf), 32'd0);
        end
        wea = 4'h0;
        rd(4'd2);
        chk("hold_mem_intact", douta_rf, 32'h1110_1010);

        // Reset mid-sweep restarts it; writes during busy are dropped.
        wr(4'd3, 32'h0000_0033, 4'hF);
        rsta = 1'b1;
        tick();
        rsta = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        chk("midsweep_busy", 32'(busy_rf), 32'd1);
        rsta = 1'b1; ena = 1'b1; wea = 4'hF; addra = 4'd3; dina = 32'h1234_5678;
        tick();
        rsta = 1'b0;
        n = 0;
        for (int k = 0; k < 100 && busy_rf; k++) begin
            n++;
            if (n == 4) begin
                ena = 1'b0; wea = 4'h0;
            end
            chk($sformatf("lockout_rvalid[%0d]", k), 32'(rvalid_rf), 32'd0);
            tick();
        end
        ena = 1'b0; wea = 4'h0;
        chk("restart_sweep_len", 32'(n), 32'd16);
        rd(4'd3);
        chk("lockout_rd_data",   douta_rf, 32'h0);
        chk("lockout_rd_rvalid", 32'(rvalid_rf), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
